fb_rect_fill: RTL

- iomem-mapped rectangle-fill engine that sits directly upstream of the 12-bit RGB framebuffer read by the VGA scan-out.
- The CPU programs origin, size and colour over the picosoc iomem bus, then writes START.
- The engine streams one framebuffer write per pixel over a valid/ready write port, row-major, clipped to the screen.
- It frees the CPU from per-pixel stores.

---
 rtl/fb_rect_fill.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fb_rect_fill.sv
// rtl/fb_rect_fill.sv - iomem-mapped rectangle fill engine feeding the 12-bit RGB framebuffer
// Optional irq_done output and CTRL/STATUS bit2 are built when FB_RECT_FILL_IRQ_EN is defined.
module fb_rect_fill #(
    parameter int         H_RES  = 640,
    parameter int         V_RES  = 480,
    parameter int         ADDR_W = 19,
    parameter logic [7:0] BASE   = 8'h06
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              iomem_valid,
    output logic              iomem_ready,
    input  logic [3:0]        iomem_wstrb,
    input  logic [31:0]       iomem_addr,
    input  logic [31:0]       iomem_wdata,
    output logic [31:0]       iomem_rdata,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [11:0]       fb_wdata,
    input  logic              fb_ready
`ifdef FB_RECT_FILL_IRQ_EN
    ,
    output logic              irq_done
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    localparam logic [11:0]       H_RES_W = 12'(H_RES);
    localparam logic [11:0]       V_RES_W = 12'(V_RES);
    localparam logic [10:0]       H_RES_X = 11'(H_RES);
    localparam logic [10:0]       V_RES_X = 11'(V_RES);
    localparam logic [ADDR_W-1:0] H_RES_A = ADDR_W'(H_RES);

    state_t              r_state, w_next;
    logic                r_ready;
    logic [31:0]         r_rdata;
    logic [2:0]          r_req_idx;
    logic [3:0]          r_req_wstrb;
    logic [31:0]         r_req_wdata;
    logic [9:0]          r_x0, r_y0;
    logic [10:0]         r_w, r_h;
    logic [11:0]         r_color;
    logic                r_done;
    logic [10:0]         r_x, r_y, r_xe, r_ye;
    logic [ADDR_W-1:0]   r_row_base;

    logic                w_sel, w_wr, w_busy, w_run, w_beat, w_irq_en;
    logic                w_cmd_start, w_cmd_abort, w_empty, w_last_col, w_last_row;
    logic [31:0]         w_mask, w_cur, w_merged, w_status, w_rd_mux;
    logic [11:0]         w_xsum, w_ysum;
    logic [10:0]         w_xe, w_ye;
    logic [ADDR_W-1:0]   w_row0;
    logic                w_unused_addr;

    assign w_sel  = iomem_valid && (iomem_addr[31:24] == BASE) && !r_ready;
    assign w_unused_addr = ^{iomem_addr[23:5], iomem_addr[1:0]};

    // Requests are captured on select and take effect in the ack cycle, so a START
    // puts the FSM in SETUP the cycle after the ack and the first pixel one cycle later.
    assign w_wr        = r_ready && (|r_req_wstrb);
    assign w_busy      = (r_state != S_IDLE);
    assign w_run       = (r_state == S_RUN);
    assign w_beat      = w_run && fb_ready;
    assign w_cmd_start = w_wr && (r_req_idx == 3'd3) && r_req_wstrb[0] && r_req_wdata[0];
    assign w_cmd_abort = w_wr && (r_req_idx == 3'd3) && r_req_wstrb[0] && r_req_wdata[1];
    assign w_mask      = {{8{r_req_wstrb[3]}}, {8{r_req_wstrb[2]}},
                          {8{r_req_wstrb[1]}}, {8{r_req_wstrb[0]}}};

    always_comb begin
        w_cur = 32'd0;
        case (r_req_idx)
            3'd0:    w_cur = {6'd0, r_y0, 6'd0, r_x0};
            3'd1:    w_cur = {5'd0, r_h, 5'd0, r_w};
            3'd2:    w_cur = {20'd0, r_color};
            default: w_cur = 32'd0;
        endcase
    end
    assign w_merged = (w_cur & ~w_mask) | (r_req_wdata & w_mask);

    assign w_xsum  = {2'b00, r_x0} + {1'b0, r_w};
    assign w_ysum  = {2'b00, r_y0} + {1'b0, r_h};
    assign w_xe    = (w_xsum > H_RES_W) ? H_RES_X : w_xsum[10:0];
    assign w_ye    = (w_ysum > V_RES_W) ? V_RES_X : w_ysum[10:0];
    assign w_empty = ({2'b00, r_x0} >= H_RES_W) || ({2'b00, r_y0} >= V_RES_W) ||
                     (r_w == 11'd0) || (r_h == 11'd0);
    assign w_row0  = ADDR_W'(r_y0) * H_RES_A;
    assign w_last_col = (r_x == r_xe - 11'd1);
    assign w_last_row = (r_y == r_ye - 11'd1);

    assign w_status = {w_run ? 16'(r_xe - r_x) : 16'd0, 13'd0, w_irq_en, r_done, w_busy};

    always_comb begin
        w_rd_mux = 32'd0;
        case (iomem_addr[4:2])
            3'd0:    w_rd_mux = {6'd0, r_y0, 6'd0, r_x0};
            3'd1:    w_rd_mux = {5'd0, r_h, 5'd0, r_w};
            3'd2:    w_rd_mux = {20'd0, r_color};
            3'd3:    w_rd_mux = w_status;
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_cmd_start && !w_cmd_abort) w_next = S_SETUP;
            S_SETUP: w_next = w_empty ? S_DONE : S_RUN;
            S_RUN:   if (w_beat && w_last_col && w_last_row) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (w_cmd_abort && w_busy) w_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b0;
            r_rdata     <= 32'd0;
            r_req_idx   <= 3'd0;
            r_req_wstrb <= 4'd0;
            r_req_wdata <= 32'd0;
            r_x0        <= 10'd0;
            r_y0        <= 10'd0;
            r_w         <= 11'd0;
            r_h         <= 11'd0;
            r_color     <= 12'd0;
            r_done      <= 1'b0;
            r_x         <= 11'd0;
            r_y         <= 11'd0;
            r_xe        <= 11'd0;
            r_ye        <= 11'd0;
            r_row_base  <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_rd_mux : 32'd0;
            if (w_sel) begin
                r_req_idx   <= iomem_addr[4:2];
                r_req_wstrb <= iomem_wstrb;
                r_req_wdata <= iomem_wdata;
            end
            if (w_wr && !w_busy) begin
                case (r_req_idx)
                    3'd0: begin r_x0 <= w_merged[9:0];  r_y0 <= w_merged[25:16]; end
                    3'd1: begin r_w  <= w_merged[10:0]; r_h  <= w_merged[26:16]; end
                    3'd2: r_color <= w_merged[11:0];
                    default: ;
                endcase
            end
            if ((r_state == S_IDLE) && w_cmd_start && !w_cmd_abort) r_done <= 1'b0;
            else if ((r_state == S_DONE) && !w_cmd_abort)          r_done <= 1'b1;
            if (r_state == S_SETUP) begin
                r_xe       <= w_xe;
                r_ye       <= w_ye;
                r_x        <= {1'b0, r_x0};
                r_y        <= {1'b0, r_y0};
                r_row_base <= w_row0;
            end else if (w_beat) begin
                if (w_last_col) begin
                    r_x        <= {1'b0, r_x0};
                    r_y        <= r_y + 11'd1;
                    r_row_base <= r_row_base + H_RES_A;
                end else begin
                    r_x <= r_x + 11'd1;
                end
            end
        end
    end

`ifdef FB_RECT_FILL_IRQ_EN
    logic r_irq_en;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                          r_irq_en <= 1'b0;
        else if (w_wr && (r_req_idx == 3'd3) && r_req_wstrb[0]) r_irq_en <= r_req_wdata[2];
    end
    assign w_irq_en = r_irq_en;
    assign irq_done = (r_state == S_DONE) && r_irq_en && !w_cmd_abort;
`else
    assign w_irq_en = 1'b0;
`endif

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign fb_we       = w_run;
    assign fb_addr     = w_run ? (r_row_base + ADDR_W'(r_x)) : '0;
    assign fb_wdata    = w_run ? r_color : 12'd0;

endmodule
